// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared constants and FSM encoding for the UART packet assembler.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Number of UART bytes that make up one output word
  localparam int PACKET_BYTES = 4;
  localparam int PACKET_W     = PACKET_BYTES * 8;
  // Staging holds every byte of a packet except the last one
  localparam int STAGE_W      = (PACKET_BYTES - 1) * 8;

  // Default inter-byte gap limit: 10 ms at 50 MHz
  localparam int TIMEOUT_CYCLES_DEFAULT = 500000;

  // Assembler states: IDLE has no partial packet, COLLECT has 1..3 bytes
  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_packet_assembler_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_packet_assembler_if
// Brief    : Byte-in / packet-out signal bundle for the UART packet assembler.
//            master = byte source and packet consumer, slave = the assembler.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_packet_assembler_if;

  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        packet_ack;
  logic [31:0] packet;
  logic        packet_valid;
  logic [1:0]  byte_count;
  logic        timeout_err;
  logic        overrun;

  modport master (
    output rx_data,
    output rx_ready,
    output packet_ack,
    input  packet,
    input  packet_valid,
    input  byte_count,
    input  timeout_err,
    input  overrun
  );

  modport slave (
    input  rx_data,
    input  rx_ready,
    input  packet_ack,
    output packet,
    output packet_valid,
    output byte_count,
    output timeout_err,
    output overrun
  );

endinterface : uart_packet_assembler_if
`default_nettype wire

// File: rtl/uart_packet_assembler_ready_sync.sv
`default_nettype none
// ============================================================================
// Module   : ready_sync
// Brief    : Synchronizes the foreign-domain rx_ready level and emits a
//            single-cycle pulse on each rising edge. The pulse is registered,
//            so the consumer acts SYNC_STAGES+1 edges after rx_ready is
//            first sampled high.
// Revision : 1.0 - initial release
// ============================================================================
module ready_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic async_in,
  output logic      pulse_out
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_pulse;

  // Flop chain, previous-value register and registered edge pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= '0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev  <= r_sync[SYNC_STAGES-1];
      r_pulse <= r_sync[SYNC_STAGES-1] & ~r_prev;
    end
  end

  assign pulse_out = r_pulse;

endmodule : ready_sync
`default_nettype wire

// File: rtl/uart_packet_assembler.sv
`default_nettype none
// ============================================================================
// Module   : uart_packet_assembler
// Brief    : Collects four UART bytes (first byte in the MSBs) into a 32-bit
//            word with valid/ack handoff, an inter-byte timeout that discards
//            partial packets, and a sticky overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module uart_packet_assembler
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int SYNC_STAGES    = 2
) (
  input wire logic              clk,
  input wire logic              rst,
  uart_packet_assembler_if.slave bus
);

  // Counter just wide enough for 0..TIMEOUT_CYCLES-1; it stops at the
  // terminal count, so it can never wrap
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] c_TMO_TERM  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    c_LAST_BYTE = 2'(PACKET_BYTES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_cnt;
  logic [1:0]          w_cnt_nxt;
  logic [STAGE_W-1:0]  r_staging;
  logic [STAGE_W-1:0]  w_staging_nxt;
  logic [CW-1:0]       r_tmo;
  logic [CW-1:0]       w_tmo_nxt;
  logic [PACKET_W-1:0] r_packet;
  logic                r_valid;
  logic                r_timeout_err;
  logic                r_overrun;
  logic                w_capture;
  logic                w_load;
  logic                w_tmo_fire;

  ready_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ready_sync (
    .clk       (clk),
    .rst       (rst),
    .async_in  (bus.rx_ready),
    .pulse_out (w_capture)
  );

  // FSM state and collection registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 2'd0;
      r_staging <= '0;
      r_tmo     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_staging <= w_staging_nxt;
      r_tmo     <= w_tmo_nxt;
    end
  end

  // Next state: a capture always takes priority over the timeout terminal count
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_staging_nxt = r_staging;
    w_tmo_nxt     = r_tmo;
    w_load        = 1'b0;
    w_tmo_fire    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tmo_nxt = '0;
        if (w_capture) begin
          w_state_nxt   = ST_COLLECT;
          w_cnt_nxt     = 2'd1;
          w_staging_nxt = {r_staging[STAGE_W-9:0], bus.rx_data};
        end
      end
      ST_COLLECT: begin
        if (w_capture) begin
          w_tmo_nxt = '0;
          if (r_cnt == c_LAST_BYTE) begin
            w_load        = 1'b1;
            w_state_nxt   = ST_IDLE;
            w_cnt_nxt     = 2'd0;
            w_staging_nxt = '0;
          end else begin
            w_cnt_nxt     = r_cnt + 2'd1;
            w_staging_nxt = {r_staging[STAGE_W-9:0], bus.rx_data};
          end
        end else if (r_tmo == c_TMO_TERM) begin
          w_tmo_fire    = 1'b1;
          w_state_nxt   = ST_IDLE;
          w_cnt_nxt     = 2'd0;
          w_staging_nxt = '0;
          w_tmo_nxt     = '0;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_cnt_nxt     = 2'd0;
        w_staging_nxt = '0;
        w_tmo_nxt     = '0;
      end
    endcase
  end

  // Output word, valid/ack handoff, overrun flag and timeout pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_packet      <= '0;
      r_valid       <= 1'b0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_tmo_fire;
      if (w_load) begin
        r_packet <= {r_staging, bus.rx_data};
        r_valid  <= 1'b1;
        // Overwriting a word nobody took is an overrun; a same-cycle ack is not
        if (r_valid && !bus.packet_ack) begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && bus.packet_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.packet       = r_packet;
  assign bus.packet_valid = r_valid;
  assign bus.byte_count   = r_cnt;
  assign bus.timeout_err  = r_timeout_err;
  assign bus.overrun      = r_overrun;

endmodule : uart_packet_assembler
`default_nettype wire
